// File: rtl/store_buffer_pkg.sv
// Store buffer shared types: entry layout, sizing and byte-merge helper.
// Imported by the store buffer interface and top.
package store_buffer_pkg;

  localparam int SB_AW    = 32;
  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_AW-3:0] addr;
    logic [31:0]      data;
    logic [3:0]       wstrb;
  } sb_entry_t;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_data,
    input logic [31:0] new_data,
    input logic [3:0]  mask
  );
    logic [31:0] r;
    r = old_data;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = new_data[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bus bundle: core store port, memory drain port, load probe.
// master = core/memory side, slave = store buffer.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int AW = SB_AW
);

  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wmask;

  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;

  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic          sb_empty;

  modport master (
    output st_valid, st_addr, st_wdata, st_wmask,
    output mem_ready, ld_addr,
    input  st_ready, mem_valid, mem_addr,
    input  mem_wdata, mem_wstrb, ld_hit, sb_empty
  );

  modport slave (
    input  st_valid, st_addr, st_wdata, st_wmask,
    input  mem_ready, ld_addr,
    output st_ready, mem_valid, mem_addr,
    output mem_wdata, mem_wstrb, ld_hit, sb_empty
  );

endinterface

// File: rtl/store_buffer.sv
// Store buffer: FIFO of aligned stores with tail merging, drained to memory.
// Provides word-granular load hit detection and an empty flag for fences.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input  logic    clk,
  input  logic    resetn,
  store_buffer_if.slave sb
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] TWO  = (PW+1)'(2);

  sb_entry_t ent [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] tail;
  logic [PW:0]   count;

  logic [AW-3:0] st_word;
  logic [AW-3:0] ld_word;
  logic          mrg;
  logic          do_st;
  logic          do_push;
  logic          do_merge;
  logic          do_pop;
  logic          hit;

  assign st_word = sb.st_addr[AW-1:2];
  assign ld_word = sb.ld_addr[AW-1:2];
  assign tail    = wr_ptr - PW'(1);

  // count >= 2 keeps the presented head out of merge reach
  assign mrg = (count >= TWO) && (st_word == ent[tail].addr);

  assign sb.st_ready  = (count != FULL) || mrg;
  assign sb.mem_valid = (count != '0);
  assign sb.sb_empty  = (count == '0);
  assign sb.mem_addr  = {ent[rd_ptr].addr, 2'b00};
  assign sb.mem_wdata = ent[rd_ptr].data;
  assign sb.mem_wstrb = ent[rd_ptr].wstrb;
  assign sb.ld_hit    = hit;

  assign do_st    = sb.st_valid && sb.st_ready
                 && (sb.st_wmask != 4'b0);
  assign do_merge = do_st && mrg;
  assign do_push  = do_st && !mrg;
  assign do_pop   = (count != '0) && sb.mem_ready;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW+1)'(i) < count)
          && (ent[rd_ptr + PW'(i)].addr == ld_word))
        hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      ent[wr_ptr].addr  <= st_word;
      ent[wr_ptr].data  <= sb.st_wdata;
      ent[wr_ptr].wstrb <= sb.st_wmask;
    end else if (do_merge) begin
      ent[tail].data  <= merge_bytes(ent[tail].data,
                                     sb.st_wdata,
                                     sb.st_wmask);
      ent[tail].wstrb <= ent[tail].wstrb | sb.st_wmask;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
// Inputs change #1 after posedge; outputs are sampled there too.
module tb_store_buffer;

  logic clk;
  logic resetn;
  int   compared;
  int   mismatched;

  store_buffer_if #(.AW(32)) sbi ();

  store_buffer #(.DEPTH(4), .AW(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sbi.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  m);
    sbi.st_valid = 1'b1;
    sbi.st_addr  = a;
    sbi.st_wdata = d;
    sbi.st_wmask = m;
    tick();
    sbi.st_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn        = 1'b0;
    sbi.st_valid  = 1'b0;
    sbi.st_addr   = '0;
    sbi.st_wdata  = '0;
    sbi.st_wmask  = '0;
    sbi.mem_ready = 1'b0;
    sbi.ld_addr   = '0;
    #1;
    compared++;
    if (sbi.mem_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mem_valid got %b want 0", sbi.mem_valid);
    end
    compared++;
    if (sbi.sb_empty !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_sb_empty got %b want 1", sbi.sb_empty);
    end
    compared++;
    if (sbi.st_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_st_ready got %b want 1", sbi.st_ready);
    end
    compared++;
    if (sbi.ld_hit !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_ld_hit got %b want 0", sbi.ld_hit);
    end
    tick();
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single();
    sbi.mem_ready = 1'b1;
    push(32'h100, 32'hDEADBEEF, 4'b1111);
    compared++;
    if (sbi.mem_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL single_valid got %b want 1", sbi.mem_valid);
    end
    compared++;
    if (sbi.mem_addr !== 32'h100) begin
      mismatched++;
      $display("FAIL single_addr got %h want 00000100", sbi.mem_addr);
    end
    compared++;
    if (sbi.mem_wdata !== 32'hDEADBEEF) begin
      mismatched++;
      $display("FAIL single_data got %h want deadbeef", sbi.mem_wdata);
    end
    compared++;
    if (sbi.mem_wstrb !== 4'b1111) begin
      mismatched++;
      $display("FAIL single_strb got %b want 1111", sbi.mem_wstrb);
    end
    tick();
    compared++;
    if (sbi.sb_empty !== 1'b1 || sbi.mem_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL single_drain got empty=%b valid=%b want 1/0",
               sbi.sb_empty, sbi.mem_valid);
    end
  endtask

  task automatic test_merge();
    sbi.mem_ready = 1'b0;
    push(32'h200, 32'h00000011, 4'b0001);
    push(32'h300, 32'h00000033, 4'b0001);
    push(32'h301, 32'h00002200, 4'b0010);
    compared++;
    if (sbi.mem_addr !== 32'h200 || sbi.mem_wdata !== 32'h11
        || sbi.mem_wstrb !== 4'b0001) begin
      mismatched++;
      $display("FAIL merge_head got %h/%h/%b want 200/11/0001",
               sbi.mem_addr, sbi.mem_wdata, sbi.mem_wstrb);
    end
    sbi.mem_ready = 1'b1;
    tick();
    compared++;
    if (sbi.mem_addr !== 32'h300 || sbi.mem_wdata !== 32'h2233
        || sbi.mem_wstrb !== 4'b0011) begin
      mismatched++;
      $display("FAIL merge_tail got %h/%h/%b want 300/2233/0011",
               sbi.mem_addr, sbi.mem_wdata, sbi.mem_wstrb);
    end
    tick();
    compared++;
    if (sbi.sb_empty !== 1'b1) begin
      mismatched++;
      $display("FAIL merge_count got empty=%b want 1", sbi.sb_empty);
    end
    // single entry: same-word store must push, not merge into head
    sbi.mem_ready = 1'b0;
    push(32'h500, 32'hAAAAAAAA, 4'b1111);
    push(32'h500, 32'h000000BB, 4'b0001);
    compared++;
    if (sbi.mem_wdata !== 32'hAAAAAAAA || sbi.mem_wstrb !== 4'b1111) begin
      mismatched++;
      $display("FAIL nomerge_head got %h/%b want aaaaaaaa/1111",
               sbi.mem_wdata, sbi.mem_wstrb);
    end
    sbi.mem_ready = 1'b1;
    tick();
    compared++;
    if (sbi.mem_valid !== 1'b1 || sbi.mem_addr !== 32'h500
        || sbi.mem_wstrb !== 4'b0001) begin
      mismatched++;
      $display("FAIL nomerge_second got v=%b %h/%b want 1 500/0001",
               sbi.mem_valid, sbi.mem_addr, sbi.mem_wstrb);
    end
    tick();
    sbi.mem_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [31:0] exp_a [3];
    sbi.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(32'h1000 + 32'(4*i), 32'(i + 1), 4'b1111);
    sbi.st_addr = 32'h100C;
    #1;
    compared++;
    if (sbi.st_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL full_merge_ready got %b want 1", sbi.st_ready);
    end
    sbi.st_valid = 1'b1;
    sbi.st_addr  = 32'h1010;
    sbi.st_wdata = 32'h5;
    sbi.st_wmask = 4'b1111;
    #1;
    compared++;
    if (sbi.st_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL full_ready got %b want 0", sbi.st_ready);
    end
    sbi.mem_ready = 1'b1;
    tick();
    compared++;
    if (sbi.mem_addr !== 32'h1004 || sbi.st_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL full_pop1 got %h rdy=%b want 1004 1",
               sbi.mem_addr, sbi.st_ready);
    end
    tick();
    sbi.st_valid = 1'b0;
    exp_a[0] = 32'h1008;
    exp_a[1] = 32'h100C;
    exp_a[2] = 32'h1010;
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (sbi.mem_valid !== 1'b1 || sbi.mem_addr !== exp_a[i]
          || sbi.mem_wdata !== 32'(i + 3)) begin
        mismatched++;
        $display("FAIL full_order%0d got v=%b %h/%h want %h/%h", i,
                 sbi.mem_valid, sbi.mem_addr, sbi.mem_wdata,
                 exp_a[i], 32'(i + 3));
      end
      tick();
    end
    compared++;
    if (sbi.sb_empty !== 1'b1) begin
      mismatched++;
      $display("FAIL full_empty got %b want 1", sbi.sb_empty);
    end
    sbi.mem_ready = 1'b0;
  endtask

  task automatic test_ld_hit();
    sbi.mem_ready = 1'b0;
    push(32'h400, 32'h1, 4'b1111);
    push(32'h404, 32'h2, 4'b1111);
    sbi.ld_addr = 32'h406;
    #1;
    compared++;
    if (sbi.ld_hit !== 1'b1) begin
      mismatched++;
      $display("FAIL ld_406 got %b want 1", sbi.ld_hit);
    end
    sbi.ld_addr = 32'h408;
    #1;
    compared++;
    if (sbi.ld_hit !== 1'b0) begin
      mismatched++;
      $display("FAIL ld_408 got %b want 0", sbi.ld_hit);
    end
    sbi.ld_addr = 32'h401;
    #1;
    compared++;
    if (sbi.ld_hit !== 1'b1) begin
      mismatched++;
      $display("FAIL ld_head got %b want 1", sbi.ld_hit);
    end
    sbi.mem_ready = 1'b1;
    tick();
    sbi.mem_ready = 1'b0;
    sbi.ld_addr = 32'h400;
    #1;
    compared++;
    if (sbi.ld_hit !== 1'b0) begin
      mismatched++;
      $display("FAIL ld_popped got %b want 0", sbi.ld_hit);
    end
    sbi.mem_ready = 1'b1;
    tick();
    sbi.mem_ready = 1'b0;
    sbi.ld_addr = 32'h404;
    #1;
    compared++;
    if (sbi.ld_hit !== 1'b0) begin
      mismatched++;
      $display("FAIL ld_drained got %b want 0", sbi.ld_hit);
    end
  endtask

  task automatic test_zero_mask();
    sbi.mem_ready = 1'b0;
    sbi.st_valid  = 1'b1;
    sbi.st_addr   = 32'h600;
    sbi.st_wdata  = 32'h12345678;
    sbi.st_wmask  = 4'b0000;
    #1;
    compared++;
    if (sbi.st_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL zm_ready got %b want 1", sbi.st_ready);
    end
    tick();
    sbi.st_valid = 1'b0;
    compared++;
    if (sbi.mem_valid !== 1'b0 || sbi.sb_empty !== 1'b1) begin
      mismatched++;
      $display("FAIL zm_empty got v=%b e=%b want 0/1",
               sbi.mem_valid, sbi.sb_empty);
    end
    push(32'h700, 32'h77777777, 4'b1111);
    push(32'h704, 32'h00000055, 4'b0001);
    push(32'h704, 32'hFFFFFFFF, 4'b0000);
    sbi.mem_ready = 1'b1;
    tick();
    compared++;
    if (sbi.mem_addr !== 32'h704 || sbi.mem_wdata[7:0] !== 8'h55
        || sbi.mem_wstrb !== 4'b0001) begin
      mismatched++;
      $display("FAIL zm_tail got %h/%h/%b want 704/..55/0001",
               sbi.mem_addr, sbi.mem_wdata, sbi.mem_wstrb);
    end
    tick();
    compared++;
    if (sbi.sb_empty !== 1'b1) begin
      mismatched++;
      $display("FAIL zm_count got %b want 1", sbi.sb_empty);
    end
    sbi.mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    sbi.mem_ready = 1'b0;
    push(32'h800, 32'h1, 4'b1111);
    push(32'h804, 32'h2, 4'b1111);
    push(32'h808, 32'h3, 4'b1111);
    sbi.mem_ready = 1'b1;
    tick();
    #1;
    resetn = 1'b0;
    #1;
    compared++;
    if (sbi.mem_valid !== 1'b0 || sbi.sb_empty !== 1'b1) begin
      mismatched++;
      $display("FAIL rmid_async got v=%b e=%b want 0/1",
               sbi.mem_valid, sbi.sb_empty);
    end
    sbi.mem_ready = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    compared++;
    if (sbi.st_ready !== 1'b1 || sbi.sb_empty !== 1'b1) begin
      mismatched++;
      $display("FAIL rmid_release got r=%b e=%b want 1/1",
               sbi.st_ready, sbi.sb_empty);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_single();
    test_merge();
    test_full();
    test_ld_hit();
    test_zero_mask();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
